matrix_input_loader: RTL and testbench



---
 rtl/matrix_input_loader.sv | 87 ++++++++
 tb/tb_matrix_input_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/matrix_input_loader.sv
// matrix_input_loader: streams m x n elements into a packed 5x5 row-major matrix bus.
// Define MATRIX_LOADER_RANGE_CHECK_EN to reject elements above ELEM_MAX.
module matrix_input_loader #(
  parameter int MAX_DIM = 5,
  parameter int ELEM_WIDTH = 8,
  parameter int ELEM_MAX = 9,
  localparam int DW = $clog2(MAX_DIM + 1),
  localparam int IW = $clog2(MAX_DIM * MAX_DIM + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [DW-1:0]                         dim_m,
  input  logic [DW-1:0]                         dim_n,
  input  logic [ELEM_WIDTH-1:0]                 elem_in,
  input  logic                                  elem_valid,
  output logic                                  elem_ready,
  output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_out,
  output logic [DW-1:0]                         m_out,
  output logic [DW-1:0]                         n_out,
  output logic [IW-1:0]                         elem_idx,
  output logic                                  done,
  output logic                                  dim_err,
  output logic                                  elem_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] row, col;
  logic [IW-1:0] slot, total;
  logic dims_ok, go, accept, bad, take, last, wrap;

  assign dims_ok = dim_m != '0 && dim_n != '0 && dim_m <= DW'(MAX_DIM) && dim_n <= DW'(MAX_DIM);
  assign go = start && state != LOAD;
  assign elem_ready = state == LOAD;
  assign done = state == DONE;
  assign accept = elem_ready && elem_valid;
  assign take = accept && !bad;
  assign slot = IW'(row) * IW'(MAX_DIM) + IW'(col);
  assign total = IW'(m_out) * IW'(n_out);
  assign last = elem_idx + 1'b1 == total;
  assign wrap = col == n_out - 1'b1;

  always_comb
    state_nx = abort ? IDLE : go && dims_ok ? LOAD : take && last ? DONE : state;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      matrix_out <= '0;
      m_out <= '0;
      n_out <= '0;
      elem_idx <= '0;
      row <= '0;
      col <= '0;
      dim_err <= 1'b0;
    end else begin
      dim_err <= !abort && go && !dims_ok;
      // abort and a fresh start share the clear; abort also forgets the dimensions
      if (abort || (go && dims_ok)) begin
        matrix_out <= '0;
        elem_idx <= '0;
        row <= '0;
        col <= '0;
        m_out <= abort ? '0 : dim_m;
        n_out <= abort ? '0 : dim_n;
      end else if (take) begin
        matrix_out[slot*ELEM_WIDTH +: ELEM_WIDTH] <= elem_in;
        elem_idx <= elem_idx + 1'b1;
        col <= wrap ? '0 : col + 1'b1;
        row <= wrap ? row + 1'b1 : row;
      end
    end

`ifdef MATRIX_LOADER_RANGE_CHECK_EN
  assign bad = elem_in > ELEM_WIDTH'(ELEM_MAX);
  always_ff @(posedge clk or negedge reset)
    if (!reset) elem_err <= 1'b0;
    else elem_err <= !abort && accept && bad;
`else
  assign bad = 1'b0;
  assign elem_err = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_input_loader.sv
// tb_matrix_input_loader: directed and random stimulus checked against an index-arithmetic model.
module tb_matrix_input_loader;
`ifdef MATRIX_LOADER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0, reset, start, abort, elem_valid;
  logic [2:0] dim_m, dim_n, m_out, n_out;
  logic [7:0] elem_in;
  logic elem_ready, done, dim_err, elem_err;
  logic [199:0] matrix_out;
  logic [4:0] elem_idx;
  int errors = 0, checks = 0;
  logic [7:0] mat [25];
  int em, en, eidx, mode;
  bit edim, eelem;

  matrix_input_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dim_m(dim_m), .dim_n(dim_n),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready), .matrix_out(matrix_out),
    .m_out(m_out), .n_out(n_out), .elem_idx(elem_idx), .done(done), .dim_err(dim_err), .elem_err(elem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [199:0] obs, logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] packed_mat();
    logic [199:0] p = '0;
    for (int k = 0; k < 25; k++) p[k*8 +: 8] = mat[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 25; k++) mat[k] = 8'd0;
    em = 0; en = 0; eidx = 0; mode = 0; edim = 1'b0; eelem = 1'b0;
  endtask

  // mode: 0 idle, 1 loading, 2 complete; slot derived from count with / and %
  task automatic model_edge();
    edim = 1'b0; eelem = 1'b0;
    if (abort) model_reset();
    else if (start && mode != 1) begin
      if (dim_m >= 1 && dim_m <= 5 && dim_n >= 1 && dim_n <= 5) begin
        for (int k = 0; k < 25; k++) mat[k] = 8'd0;
        em = int'(dim_m); en = int'(dim_n); eidx = 0; mode = 1;
      end else edim = 1'b1;
    end else if (mode == 1 && elem_valid) begin
      if (RC && elem_in > 8'd9) eelem = 1'b1;
      else begin
        mat[(eidx / en) * 5 + eidx % en] = elem_in;
        eidx++;
        if (eidx == em * en) mode = 2;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".matrix"}, matrix_out, packed_mat());
    chk({tag, ".m"}, m_out, em);
    chk({tag, ".n"}, n_out, en);
    chk({tag, ".idx"}, elem_idx, eidx);
    chk({tag, ".done"}, done, mode == 2);
    chk({tag, ".ready"}, elem_ready, mode == 1);
    chk({tag, ".dim_err"}, dim_err, edim);
    chk({tag, ".elem_err"}, elem_err, eelem);
  endtask

  task automatic step(string tag, bit s, bit a, int m, int n, bit v, int e);
    start = s; abort = a; dim_m = 3'(m); dim_n = 3'(n); elem_valid = v; elem_in = 8'(e);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [199:0] x;
    reset = 1'b0; start = 1'b0; abort = 1'b0; dim_m = '0; dim_n = '0; elem_valid = 1'b0; elem_in = '0;
    model_reset();
    #3 check_all("reset");
    @(negedge clk) reset = 1'b1;

    step("t1_start", 1, 0, 2, 3, 0, 0);
    for (int k = 1; k <= 6; k++) step("t1_elem", 0, 0, 0, 0, 1, k);
    chk("t1_done_at_7", done, 1'b1);
    x = '0; x[7:0] = 8'd1; x[15:8] = 8'd2; x[23:16] = 8'd3; x[47:40] = 8'd4; x[55:48] = 8'd5; x[63:56] = 8'd6;
    chk("t1_matrix", matrix_out, x);
    step("t1_hold", 0, 0, 0, 0, 1, 77);

    step("t2_abort", 0, 1, 0, 0, 0, 0);
    step("t2_m0", 1, 0, 0, 3, 0, 0);
    chk("t2_dim_err0", dim_err, 1'b1);
    step("t2_gap", 0, 0, 0, 0, 1, 5);
    step("t2_m6", 1, 0, 6, 2, 0, 0);
    chk("t2_dim_err6", dim_err, 1'b1);
    step("t2_idle", 0, 0, 0, 0, 1, 5);

    step("t3_start", 1, 0, 5, 5, 0, 0);
    for (int i = 0; i < 50; i++) step("t3_elem", 0, 0, 0, 0, i % 2 == 0, $urandom_range(0, 255));
    chk("t3_idx25", elem_idx, 5'd25);
    chk("t3_done", done, 1'b1);
    step("t3_bad_start_in_done", 1, 0, 7, 1, 0, 0);
    step("t3_hold", 0, 0, 0, 0, 0, 0);

    step("t4_start", 1, 0, 2, 2, 0, 0);
    step("t4_e", 0, 0, 0, 0, 1, 9);
    step("t4_e", 0, 0, 0, 0, 1, 8);
    step("t4_e", 0, 0, 0, 0, 1, 7);
    step("t4_abort", 1, 1, 3, 3, 1, 6);
    chk("t4_cleared", matrix_out, 200'd0);
    step("t4_restart", 1, 0, 2, 2, 0, 0);
    for (int k = 4; k >= 1; k--) step("t4_e2", 0, 0, 0, 0, 1, k);
    x = '0; x[7:0] = 8'd4; x[15:8] = 8'd3; x[47:40] = 8'd2; x[55:48] = 8'd1;
    chk("t4_matrix", matrix_out, x);

    step("t5_start", 1, 0, 1, 2, 0, 0);
    step("t5_e5", 0, 0, 0, 0, 1, 5);
    step("t5_e12", 0, 0, 0, 0, 1, 12);
    step("t5_e7", 0, 0, 0, 0, 1, 7);
    step("t5_idle", 0, 0, 0, 0, 0, 0);
    x = '0; x[7:0] = 8'd5; x[15:8] = RC ? 8'd7 : 8'd12;
    chk("t5_matrix", matrix_out, x);
    chk("t5_done", done, 1'b1);

    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 11) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 15));

    step("t7_abort", 0, 1, 0, 0, 0, 0);
    step("t7_start", 1, 0, 3, 3, 0, 0);
    for (int k = 1; k <= 4; k++) step("t7_e", 0, 0, 0, 0, 1, k + 1);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("t7_async_reset");
    start = 1'b0; elem_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    step("t7_after", 1, 0, 1, 1, 0, 0);
    step("t7_after_e", 0, 0, 0, 0, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
